conv_stream_to_axi: RTL and testbench

CONV_STREAM_TO_AXI -- requirements
Module: conv_stream_to_axi

---
 rtl/phj_pkg.sv | 16 +
 rtl/conv_stream_to_axi_lane_fifo.sv | 56 +++++
 rtl/conv_stream_to_axi.sv | 130 +++++++++++++
 tb/tb_conv_stream_to_axi.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/phj_pkg.sv
// Shared constants and state encoding for the lane-to-beat stream converter.
package phj_pkg;

    localparam int unsigned NUM_LANES = 8;
    localparam int unsigned TUPLE_W   = 64;
    localparam int unsigned SN_W      = 32;
    localparam int unsigned TAG_W     = 64;
    localparam int unsigned ENTRY_W   = TUPLE_W + TAG_W;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/conv_stream_to_axi_lane_fifo.sv
// Per-lane synchronous FIFO; head word is presented combinationally on rd_data.
module lane_fifo #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_wr;
    logic             do_rd;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_data;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/conv_stream_to_axi.sv
// Joins eight independently flowing lanes into one 512-bit beat stream,
// checking per-lane serial tags and finishing once every lane reports last.
module conv_stream_to_axi
    import phj_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CHECK_SN   = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [511:0] in_data,
    input  logic [7:0]   in_valid,
    output logic [7:0]   in_ready,
    input  logic [511:0] in_serialnum,
    input  logic [7:0]   in_last,
    output logic [511:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic [31:0]  curr_sn,
    output logic         sn_err
);

    logic [ENTRY_W-1:0] head [NUM_LANES];
    logic [7:0]         full;
    logic [7:0]         empty;
    logic [7:0]         wr_en;
    logic               all_head;
    logic               load;

    state_t             state_q, state_d;
    logic [511:0]       out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [SN_W-1:0]    curr_sn_q, curr_sn_d;
    logic               sn_err_q, sn_err_d;
    logic               last_seen_q, last_seen_d;

    assign in_ready = ~full & {8{state_q != DONE}};
    assign wr_en    = in_valid & in_ready;
    assign all_head = &(~empty);
    assign load     = all_head && (!out_valid_q || out_ready) && (state_q != DONE);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lane_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .resetn  (resetn),
            .wr_en   (wr_en[g]),
            .wr_data ({in_serialnum[g*TAG_W +: TAG_W], in_data[g*TUPLE_W +: TUPLE_W]}),
            .rd_en   (load),
            .rd_data (head[g]),
            .full    (full[g]),
            .empty   (empty[g])
        );
    end

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        curr_sn_d   = curr_sn_q;
        sn_err_d    = sn_err_q;
        last_seen_d = &in_last;

        if (load) begin
            out_valid_d = 1'b1;
            curr_sn_d   = curr_sn_q + 32'd1;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                out_data_d[i*TUPLE_W +: TUPLE_W] = head[i][TUPLE_W-1:0];
                // Tag layout: [31:0] beat number, [63:32] lane index.
                if ((CHECK_SN != 0) &&
                    ((head[i][TUPLE_W +: SN_W] != curr_sn_q) ||
                     (head[i][TUPLE_W+SN_W +: SN_W] != SN_W'(i)))) begin
                    sn_err_d = 1'b1;
                end
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            RUN: begin
                if (last_seen_q) state_d = DRAIN;
            end
            DRAIN: begin
                if ((&empty) && (!out_valid_q || out_ready)) begin
                    state_d     = DONE;
                    out_last_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            end
            DONE: begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= RUN;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            curr_sn_q   <= '0;
            sn_err_q    <= 1'b0;
            last_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            curr_sn_q   <= curr_sn_d;
            sn_err_q    <= sn_err_d;
            last_seen_q <= last_seen_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign curr_sn   = curr_sn_q;
    assign sn_err    = sn_err_q;

endmodule

// File: tb/tb_conv_stream_to_axi.sv
// Directed bench for conv_stream_to_axi: latency, backpressure, tag errors, wrap and end-of-stream.
module tb_conv_stream_to_axi;
    import phj_pkg::*;

    logic         clk = 1'b0;
    logic         resetn;
    logic [511:0] in_data;
    logic [7:0]   in_valid;
    logic [7:0]   in_ready;
    logic [511:0] in_serialnum;
    logic [7:0]   in_last;
    logic [511:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [31:0]  curr_sn;
    logic         sn_err;

    int checks = 0;
    int errors = 0;
    int nbeats = 0;

    always #5 clk = ~clk;

    conv_stream_to_axi #(
        .FIFO_DEPTH (4),
        .CHECK_SN   (1)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_serialnum (in_serialnum),
        .in_last      (in_last),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .curr_sn      (curr_sn),
        .sn_err       (sn_err)
    );

    always @(posedge clk) begin
        if (resetn && out_valid && out_ready) nbeats++;
    end

    function automatic logic [63:0] dword(input int unsigned k, input int unsigned i);
        return (64'(k) << 16) + 64'h100 + 64'(i);
    endfunction

    function automatic logic [511:0] beat(input int unsigned k);
        logic [511:0] b;
        for (int unsigned i = 0; i < 8; i++) b[i*64 +: 64] = dword(k, i);
        return b;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input int unsigned k, input logic [31:0] sn, input int bad);
        for (int i = 0; i < 8; i++) begin
            in_data[i*64 +: 64]      = dword(k, i);
            in_serialnum[i*64 +: 64] = {32'(i), (i == bad) ? sn + 32'd1 : sn};
        end
    endtask

    task automatic push(input int unsigned k, input logic [31:0] sn, input int bad);
        int n = 0;
        set_lanes(k, sn, bad);
        while (in_ready !== 8'hFF && n < 20) begin
            tick();
            n++;
        end
        chk("push_ready", {504'd0, in_ready}, {504'd0, 8'hFF});
        in_valid = 8'hFF;
        tick();
        in_valid = 8'h00;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        int n;
        int base;
        resetn       = 1'b0;
        in_data      = '0;
        in_valid     = '0;
        in_serialnum = '0;
        in_last      = '0;
        out_ready    = 1'b1;
        do_reset();

        // Reset values
        chk("rst_in_ready", {504'd0, in_ready}, {504'd0, 8'hFF});
        chk("rst_out_valid", {511'd0, out_valid}, 512'd0);
        chk("rst_out_last", {511'd0, out_last}, 512'd0);
        chk("rst_curr_sn", {480'd0, curr_sn}, 512'd0);
        chk("rst_sn_err", {511'd0, sn_err}, 512'd0);
        chk("rst_out_data", out_data, 512'd0);

        // All lanes together: beat visible one edge after the handshake edge
        push(0, 32'd0, -1);
        chk("t1_valid_early", {511'd0, out_valid}, 512'd0);
        tick();
        chk("t1_valid", {511'd0, out_valid}, 512'd1);
        chk("t1_data", out_data, beat(0));
        chk("t1_sn", {480'd0, curr_sn}, 512'd1);
        chk("t1_err", {511'd0, sn_err}, 512'd0);
        tick();
        chk("t1_valid_drop", {511'd0, out_valid}, 512'd0);

        // Lane 7 arrives five cycles late
        set_lanes(1, 32'd1, -1);
        in_valid = 8'h7F;
        tick();
        in_valid = 8'h00;
        for (int c = 0; c < 5; c++) begin
            chk("t2_wait_valid", {511'd0, out_valid}, 512'd0);
            tick();
        end
        in_valid = 8'h80;
        tick();
        in_valid = 8'h00;
        chk("t2_valid_early", {511'd0, out_valid}, 512'd0);
        tick();
        chk("t2_valid", {511'd0, out_valid}, 512'd1);
        chk("t2_data", out_data, beat(1));
        chk("t2_sn", {480'd0, curr_sn}, 512'd2);
        tick();
        chk("t2_single", {511'd0, out_valid}, 512'd0);
        chk("t2_err", {511'd0, sn_err}, 512'd0);

        // Backpressure: beat 0 held in output, beats 1..4 fill the FIFOs
        do_reset();
        out_ready = 1'b0;
        for (int unsigned k = 0; k < 5; k++) push(k, 32'(k), -1);
        chk("t3_full", {504'd0, in_ready}, 512'd0);
        chk("t3_valid", {511'd0, out_valid}, 512'd1);
        chk("t3_data", out_data, beat(0));
        chk("t3_sn", {480'd0, curr_sn}, 512'd1);
        tick();
        tick();
        tick();
        chk("t3_hold_data", out_data, beat(0));
        chk("t3_hold_valid", {511'd0, out_valid}, 512'd1);
        chk("t3_hold_ready", {504'd0, in_ready}, 512'd0);
        out_ready = 1'b1;
        for (int unsigned k = 1; k < 5; k++) begin
            tick();
            chk("t3_order_data", out_data, beat(k));
            chk("t3_order_valid", {511'd0, out_valid}, 512'd1);
        end
        tick();
        chk("t3_end_valid", {511'd0, out_valid}, 512'd0);
        chk("t3_end_sn", {480'd0, curr_sn}, 512'd5);
        chk("t3_err", {511'd0, sn_err}, 512'd0);

        // Lane 3 mis-tagged on beat 0; error stays sticky
        do_reset();
        push(0, 32'd0, 3);
        tick();
        chk("t4_valid", {511'd0, out_valid}, 512'd1);
        chk("t4_data", out_data, beat(0));
        chk("t4_err", {511'd0, sn_err}, 512'd1);
        for (int unsigned k = 1; k < 11; k++) push(k, 32'(k), -1);
        tick();
        tick();
        chk("t4_err_sticky", {511'd0, sn_err}, 512'd1);
        chk("t4_sn", {480'd0, curr_sn}, 512'd11);

        // Serial number wrap
        do_reset();
        force dut.curr_sn_q = 32'hFFFF_FFFF;
        tick();
        release dut.curr_sn_q;
        push(0, 32'hFFFF_FFFF, -1);
        push(1, 32'd0, -1);
        tick();
        tick();
        chk("t5_err", {511'd0, sn_err}, 512'd0);
        chk("t5_sn", {480'd0, curr_sn}, 512'd1);
        chk("t5_data", out_data, beat(1));

        // End of stream
        do_reset();
        base = nbeats;
        for (int unsigned k = 0; k < 8; k++) push(k, 32'(k), -1);
        in_last = 8'hFF;
        n = 0;
        while (out_last !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("t6_out_last", {511'd0, out_last}, 512'd1);
        chk("t6_beats", 512'(nbeats - base), 512'd8);
        chk("t6_in_ready", {504'd0, in_ready}, 512'd0);
        chk("t6_valid", {511'd0, out_valid}, 512'd0);
        chk("t6_state", {510'd0, dut.state_q}, {510'd0, DONE});
        chk("t6_sn", {480'd0, curr_sn}, 512'd8);
        set_lanes(8, 32'd8, -1);
        in_valid = 8'hFF;
        tick();
        tick();
        in_valid = 8'h00;
        chk("t6_done_ready", {504'd0, in_ready}, 512'd0);
        chk("t6_done_last", {511'd0, out_last}, 512'd1);
        chk("t6_done_valid", {511'd0, out_valid}, 512'd0);
        in_last = 8'h00;
        do_reset();
        chk("t6_rst_last", {511'd0, out_last}, 512'd0);
        chk("t6_rst_ready", {504'd0, in_ready}, {504'd0, 8'hFF});
        chk("t6_rst_sn", {480'd0, curr_sn}, 512'd0);
        chk("t6_rst_data", out_data, 512'd0);
        chk("t6_rst_valid", {511'd0, out_valid}, 512'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
